// File: rtl/udma_evt_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : udma_evt_collector_if
//  Description : Event queue output handshake between the collector and the
//                downstream event matcher.
//  Revision    : 1.0 - initial release
// ============================================================================
interface udma_evt_collector_if;
    logic       evt_valid_o;
    logic [7:0] evt_data_o;
    logic       evt_ready_i;
    logic       evt_lost_o;

    modport master (
        output evt_valid_o,
        output evt_data_o,
        output evt_lost_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_data_o,
        input  evt_lost_o,
        output evt_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/udma_evt_collector.sv
`default_nettype none
// ============================================================================
//  Module      : udma_evt_collector
//  Description : Latches per-line peripheral events, arbitrates them
//                round-robin into a small FIFO of event IDs and flags drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module udma_evt_collector #(
    parameter int NB_EVT     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NB_EVT-1:0]          evt_i,
    udma_evt_collector_if.master       evt_if
);

    localparam int c_RR_W  = $clog2(NB_EVT);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_RR_W-1:0]  c_LAST_EVT = c_RR_W'(NB_EVT - 1);

    logic [NB_EVT-1:0]  r_pending;
    logic [NB_EVT-1:0]  w_hi;
    logic [NB_EVT-1:0]  w_gnt_oh;
    logic [c_RR_W-1:0]  r_rr;
    logic [c_RR_W-1:0]  w_gnt_idx;
    logic               w_can_grant;
    logic               w_grant;
    logic               w_pop;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] w_rd_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;

    logic               r_valid;
    logic               r_lost;
    logic [7:0]         r_data;
    logic [7:0]         w_head_nxt;
    logic [7:0]         w_push_data;

    // A full queue blocks the grant even if the head is popped this cycle.
    assign w_can_grant = (r_count != c_FULL);
    assign w_grant     = w_can_grant && (|r_pending);
    assign w_pop       = r_valid && evt_if.evt_ready_i;
    assign w_push_data = 8'(w_gnt_idx);

    // Round-robin: lowest pending line at or above rr, else lowest overall.
    always_comb begin
        w_hi      = '0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        for (int i = 0; i < NB_EVT; i++) begin
            w_hi[i] = r_pending[i] && (c_RR_W'(i) >= r_rr);
        end
        for (int i = NB_EVT - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_gnt_idx = c_RR_W'(i);
            end
        end
        if (|w_hi) begin
            for (int i = NB_EVT - 1; i >= 0; i--) begin
                if (w_hi[i]) begin
                    w_gnt_idx = c_RR_W'(i);
                end
            end
        end
        for (int i = 0; i < NB_EVT; i++) begin
            w_gnt_oh[i] = w_grant && (w_gnt_idx == c_RR_W'(i));
        end
    end

    assign w_rd_nxt    = r_rd_ptr + c_PTR_W'(w_pop);
    assign w_count_nxt = r_count + c_CNT_W'(w_grant) - c_CNT_W'(w_pop);

    // When the queue drains to zero before this cycle's push, the pushed ID
    // becomes the new head directly.
    always_comb begin
        w_head_nxt = 8'h00;
        if (w_count_nxt != '0) begin
            if (r_count == c_CNT_W'(w_pop)) begin
                w_head_nxt = w_push_data;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pending <= '0;
            r_rr      <= '0;
            r_lost    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_gnt_oh) | evt_i;
            r_lost    <= |(evt_i & r_pending & ~w_gnt_oh);
            if (w_grant) begin
                r_rr <= (w_gnt_idx == c_LAST_EVT) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            if (w_grant) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != '0);
            r_data   <= w_head_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign evt_if.evt_valid_o = r_valid;
    assign evt_if.evt_data_o  = r_data;
    assign evt_if.evt_lost_o  = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_udma_evt_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udma_evt_collector
//  Description : Scoreboard bench for udma_evt_collector with a queue-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udma_evt_collector;

    localparam int NB_EVT     = 12;
    localparam int FIFO_DEPTH = 4;

    logic              clk    = 1'b0;
    logic              rstn_i = 1'b1;
    logic [NB_EVT-1:0] evt_i  = '0;

    udma_evt_collector_if ev_if();

    always #5 clk = ~clk;

    udma_evt_collector #(
        .NB_EVT     (NB_EVT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn_i),
        .evt_i  (evt_i),
        .evt_if (ev_if)
    );

    int checks   = 0;
    int errors   = 0;
    int mq[$];      // model FIFO contents
    int sb[$];      // expected delivery order
    int dlog[$];    // IDs actually delivered
    int elog[$];
    bit pend [NB_EVT];
    int rr       = 0;
    bit exp_lost = 1'b0;
    int lost_cnt = 0;
    int m_g;
    int m_sz;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        sb.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        rr       = 0;
        exp_lost = 1'b0;
    endtask

    // Reference model: pending set, rotating pointer and a bounded queue.
    always @(posedge clk) begin
        if (rstn_i) begin
            m_sz = mq.size();
            m_g  = -1;
            if (m_sz < FIFO_DEPTH) begin
                for (int k = 0; k < NB_EVT; k++) begin
                    if (m_g < 0 && pend[(rr + k) % NB_EVT]) m_g = (rr + k) % NB_EVT;
                end
            end
            exp_lost = 1'b0;
            for (int i = 0; i < NB_EVT; i++) begin
                if (evt_i[i] && pend[i] && i != m_g) exp_lost = 1'b1;
            end
            if (m_sz > 0 && ev_if.evt_ready_i) void'(mq.pop_front());
            if (m_g >= 0) begin
                mq.push_back(m_g);
                sb.push_back(m_g);
                rr = (m_g + 1) % NB_EVT;
            end
            for (int i = 0; i < NB_EVT; i++) begin
                pend[i] = (pend[i] && i != m_g) || evt_i[i];
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle, pops the scoreboard on handshake.
    always @(negedge clk) begin
        if (rstn_i) begin
            chk("valid", int'(ev_if.evt_valid_o), int'(mq.size() != 0));
            chk("lost", int'(ev_if.evt_lost_o), int'(exp_lost));
            if (ev_if.evt_lost_o) lost_cnt++;
            if (!ev_if.evt_valid_o) begin
                chk("data_idle", int'(ev_if.evt_data_o), 0);
            end else if (ev_if.evt_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_delivery", int'(ev_if.evt_data_o), -1);
                end else begin
                    chk("data", int'(ev_if.evt_data_o), sb.pop_front());
                end
                dlog.push_back(int'(ev_if.evt_data_o));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int line);
        evt_i       = '0;
        evt_i[line] = 1'b1;
        tick();
        evt_i = '0;
    endtask

    task automatic apply_reset();
        rstn_i = 1'b0;
        model_clear();
        evt_i = '0;
        repeat (2) tick();
        rstn_i = 1'b1;
        dlog.delete();
        lost_cnt = 0;
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, dlog.size(), elog.size());
        for (int i = 0; i < dlog.size() && i < elog.size(); i++) begin
            chk({name, "_id"}, dlog[i], elog[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ev_if.evt_ready_i = 1'b0;
        #1 rstn_i = 1'b0;
        model_clear();
        #1;
        chk("rst_valid", int'(ev_if.evt_valid_o), 0);
        chk("rst_data", int'(ev_if.evt_data_o), 0);
        chk("rst_lost", int'(ev_if.evt_lost_o), 0);
        repeat (2) tick();
        rstn_i = 1'b1;

        // Single pulse on line 5
        ev_if.evt_ready_i = 1'b1;
        tick();
        dlog.delete();
        lost_cnt = 0;
        pulse(5);
        repeat (5) tick();
        elog = {5};
        check_log("single");
        chk("single_lost", lost_cnt, 0);

        // Simultaneous pairs exercise the rotating pointer
        apply_reset();
        ev_if.evt_ready_i = 1'b1;
        evt_i = '0; evt_i[3] = 1'b1; evt_i[7] = 1'b1;
        tick();
        evt_i = '0;
        repeat (5) tick();
        evt_i = '0; evt_i[2] = 1'b1; evt_i[9] = 1'b1;
        tick();
        evt_i = '0;
        repeat (5) tick();
        elog = {3, 7, 9, 2};
        check_log("rr");

        // Six lines against a stalled 4-deep queue
        apply_reset();
        ev_if.evt_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) pulse(i);
        repeat (3) tick();
        chk("sat_count", mq.size(), FIFO_DEPTH);
        ev_if.evt_ready_i = 1'b1;
        repeat (12) tick();
        elog = {0, 1, 2, 3, 4, 5};
        check_log("sat");
        chk("sat_lost", lost_cnt, 0);

        // Repeat event on a pending line while full
        apply_reset();
        ev_if.evt_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) pulse(i);
        tick();
        pulse(4);
        repeat (2) tick();
        pulse(4);
        repeat (3) tick();
        chk("drop_lost", lost_cnt, 1);
        ev_if.evt_ready_i = 1'b1;
        repeat (10) tick();
        elog = {0, 1, 2, 3, 4};
        check_log("drop");

        // Line held high for four cycles
        apply_reset();
        ev_if.evt_ready_i = 1'b1;
        evt_i = '0; evt_i[1] = 1'b1;
        repeat (4) tick();
        evt_i = '0;
        repeat (6) tick();
        elog = {1, 1, 1, 1};
        check_log("held");
        chk("held_lost", lost_cnt, 0);

        // Asynchronous reset with entries queued
        apply_reset();
        ev_if.evt_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) pulse(i);
        repeat (2) tick();
        chk("pre_rst_valid", int'(ev_if.evt_valid_o), 1);
        #3 rstn_i = 1'b0;
        model_clear();
        #1;
        chk("async_valid", int'(ev_if.evt_valid_o), 0);
        chk("async_data", int'(ev_if.evt_data_o), 0);
        repeat (2) tick();
        rstn_i = 1'b1;
        dlog.delete();
        ev_if.evt_ready_i = 1'b1;
        repeat (10) tick();
        chk("post_rst_len", dlog.size(), 0);
        pulse(6);
        repeat (4) tick();
        elog = {6};
        check_log("post_rst");

        // Randomized traffic
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NB_EVT; i++) evt_i[i] = ($urandom_range(7) == 0);
            ev_if.evt_ready_i = ($urandom_range(9) < 7);
            tick();
        end
        evt_i = '0;
        ev_if.evt_ready_i = 1'b1;
        repeat (30) tick();
        chk("rand_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
